// File: rtl/ram_reader.sv
// Reads RAM addresses 0..31 and presents each byte as two nibbles under a V/E handshake.
// Optional RAM_READER_WRAP_EN: wrap 31->0 and keep reading until reset.
module ram_reader (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       E,
  input  logic [7:0] DOUT,
  output logic [4:0] RADD,
  output logic       R,
  output logic [3:0] data,
  output logic       V,
  output logic       done,
  output logic [4:0] led1
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    HI    = 3'd3,
    LO    = 3'd4,
    NEXT  = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] radd_q, radd_d;
  logic [7:0] hold_q, hold_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      radd_q  <= 5'd0;
      hold_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      radd_q  <= radd_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    radd_d  = radd_q;
    hold_d  = hold_q;
    R       = 1'b0;
    V       = 1'b0;
    data    = 4'd0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          radd_d  = 5'd0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        R       = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        // RAM data lands the cycle after R
        hold_d  = DOUT;
        state_d = HI;
      end
      HI: begin
        V    = 1'b1;
        data = hold_q[7:4];
        if (E) state_d = LO;
      end
      LO: begin
        V    = 1'b1;
        data = hold_q[3:0];
        if (E) state_d = NEXT;
      end
      NEXT: begin
        if (radd_q == 5'd31) begin
          done   = 1'b1;
          radd_d = 5'd0;
`ifdef RAM_READER_WRAP_EN
          state_d = FETCH;
`else
          state_d = IDLE;
`endif
        end else begin
          radd_d  = radd_q + 5'd1;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign RADD = radd_q;
  assign led1 = {2'b00, state_q};

endmodule

// File: tb/tb_ram_reader.sv
// Directed bench for ram_reader: reset, stall/hold, full streaming pass,
// ignored start, mid-readout reset and restart.
module tb_ram_reader;

  logic       clk = 1'b0;
  logic       reset, start, E;
  logic [7:0] DOUT;
  logic [4:0] RADD;
  logic       R, V, done;
  logic [3:0] data;
  logic [4:0] led1;

  logic [7:0] mem [32];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk)
    if (R) DOUT <= mem[RADD];

  ram_reader dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .E    (E),
    .DOUT (DOUT),
    .RADD (RADD),
    .R    (R),
    .data (data),
    .V    (V),
    .done (done),
    .led1 (led1)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               tag, got, got, exp, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_V", V, 0);
    chk("rst_R", R, 0);
    chk("rst_radd", RADD, 0);
    chk("rst_data", data, 0);
    chk("rst_done", done, 0);
    chk("rst_led1", led1, 0);
  endtask

  // mode 0: full pass, 1: stray start at RADD=5, 2: reset in LO at RADD=17
  task automatic run_stream(input int mode);
    int idx, t, dones, fetches, b;
    bit fin, post;
    int exp_n;
    idx = 0; t = 0; dones = 0; fetches = 0;
    fin = 0; post = 0;
    E = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 1;
    while (!fin && t < 1000) begin
      if (post) begin
        chk("post_led1", led1, 0);
        chk("post_done", done, 0);
        fin = 1;
      end else begin
        if (V) begin
          b = idx / 2;
          exp_n = (idx % 2) ? mem[b % 32][3:0] : mem[b % 32][7:4];
          chk("nib", data, exp_n);
          if (idx % 2 == 0) chk("lat", t, 3 + 5 * b);
          idx++;
        end else begin
          chk("data0", data, 0);
        end
        if (R) begin
          chk("radd", RADD, fetches % 32);
          fetches++;
        end
        if (done) begin
          dones++;
          chk("done_at", idx, 64 * dones);
`ifndef RAM_READER_WRAP_EN
          post = 1;
`endif
        end
`ifdef RAM_READER_WRAP_EN
        if (idx >= 140) begin
          chk("wrap_dones", dones, 2);
          fin = 1;
        end
`endif
        start = (mode == 1 && R && RADD == 5);
        if (mode == 2 && led1 == 4 && RADD == 17) begin
          reset = 1'b1;
          @(negedge clk);
          reset = 1'b0;
          chk("mrst_V", V, 0);
          chk("mrst_radd", RADD, 0);
          chk("mrst_R", R, 0);
          chk("mrst_done", done, 0);
          chk("mrst_led1", led1, 0);
          chk("mrst_dones", dones, 0);
          fin = 1;
        end
      end
      if (!fin) begin
        @(negedge clk);
        t++;
      end
    end
    if (!fin) chk("timeout", 0, 1);
    start = 1'b0;
    E = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    E = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 8'(i * 8 + 3);
    @(negedge clk);
    do_reset();

    // stall on the high nibble, then step with single E pulses
    mem[0] = 8'hA5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("f_led1", led1, 1);
    chk("f_R", R, 1);
    chk("f_radd", RADD, 0);
    @(negedge clk);
    chk("w_led1", led1, 2);
    chk("w_R", R, 0);
    chk("w_V", V, 0);
    @(negedge clk);
    chk("hi_V", V, 1);
    chk("hi_data", data, 4'hA);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_V", V, 1);
      chk("hold_data", data, 4'hA);
    end
    E = 1'b1;
    @(negedge clk);
    E = 1'b0;
    chk("lo_data", data, 4'h5);
    chk("lo_led1", led1, 4);
    @(negedge clk);
    chk("lo_hold", data, 4'h5);
    E = 1'b1;
    @(negedge clk);
    E = 1'b0;
    chk("nx_V", V, 0);
    chk("nx_data", data, 0);
    chk("nx_led1", led1, 5);
    chk("nx_done", done, 0);
    do_reset();
    mem[0] = 8'h03;

    run_stream(0);
    do_reset();
    run_stream(1);
    do_reset();
    run_stream(2);
    run_stream(0);
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ram_reader.md
RAM_READER -- requirements
Module: RamReader

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock; all logic on posedge clk.
REQ-002 SHALL have: reset  input  1  reset, synchronous, active-high.
REQ-003 SHALL have: start  input  1  one-cycle pulse; begins a readout of RAM addresses 0..31.
REQ-004 SHALL have: E  input  1  consumer strobe; E=1 with V=1 on a clock edge consumes the presented nibble.
REQ-005 SHALL have: DOUT  input  8  RAM read data, valid one cycle after R=1.
REQ-006 SHALL have: RADD  output  5  RAM read address.
REQ-007 SHALL have: R  output  1  RAM read enable.
REQ-008 SHALL have: data  output  4  presented nibble.
REQ-009 SHALL have: V  output  1  data valid.
REQ-010 SHALL have: done  output  1  one-cycle pulse after the last nibble is consumed.
REQ-011 SHALL have: led1  output  5  zero-extended state code, for debug.

Function
REQ-012 SHALL implement the states IDLE=0, FETCH=1, WAIT=2, HI=3, LO=4, NEXT=5; any other code SHALL go to IDLE on the next cycle.
REQ-013 IDLE: R=0 and V=0; start=1 SHALL set RADD=0 and go to FETCH.
REQ-014 FETCH: R=1 for exactly one cycle at the current RADD; then go to WAIT.
REQ-015 WAIT: R=0; DOUT SHALL be latched into an 8-bit holding register; then go to HI.
REQ-016 HI: data=hold[7:4] and V=1; E=1 SHALL go to LO; E=0 SHALL hold the state.
REQ-017 LO: data=hold[3:0] and V=1; E=1 SHALL go to NEXT; E=0 SHALL hold the state.
REQ-018 NEXT: V=0; if RADD=31, SHALL pulse done=1, set RADD=0 and go to IDLE; otherwise SHALL set RADD=RADD+1 and go to FETCH.
REQ-019 Latency: start to the first V=1 SHALL be 3 cycles; the LO accept to the next HI V=1 SHALL be 4 cycles.
REQ-020 E received while V=0 SHALL be ignored; E held high SHALL consume one nibble per cycle.
REQ-021 start outside IDLE SHALL be ignored.
REQ-022 RADD SHALL stay within 0..31 and SHALL never be presented as 32; the 32nd byte SHALL end the readout.
REQ-023 data SHALL be 0 whenever V=0.

Reset
REQ-024 reset=1 SHALL, on the next edge, force state=IDLE, RADD=0, R=0, data=0, V=0, done=0, hold=0 and led1=0.
REQ-025 reset SHALL take priority over start and E in the same cycle.
REQ-026 reset mid-readout SHALL abandon the readout with no done pulse; a later start SHALL restart at address 0.

Configuration
REQ-027 When macro RAM_READER_WRAP_EN is defined, NEXT at RADD=31 SHALL still pulse done, but SHALL set RADD=0 and go to FETCH, reading continuously until reset.
REQ-028 When RAM_READER_WRAP_EN is not defined, the behaviour of REQ-018 SHALL apply: a single 32-byte pass, then IDLE.

Verification
REQ-029 Fill the RAM model with mem[i]=i*8+3, pulse start, and hold E=1: the bench SHALL see 64 nibbles in order {mem[i][7:4], mem[i][3:0]}, one done pulse after the 64th nibble, then led1=0.
REQ-030 Pulse start with mem[0]=0xA5 and E=0: V rises 3 cycles after start with data=0xA; V and data SHALL hold for 10 cycles; an E pulse gives data=0x5 on the next cycle.
REQ-031 Assert reset while in LO at RADD=17: the next cycle SHALL show V=0, RADD=0, R=0 and no done pulse; a following start SHALL read address 0 first.
REQ-032 Pulse start again mid-readout at RADD=5: the readout SHALL be unaffected and RADD SHALL continue 6, 7, ...
REQ-033 Pulse E while in IDLE or WAIT: the nibble sequence SHALL be unchanged and nothing SHALL be skipped.
REQ-034 With RAM_READER_WRAP_EN defined, read 70 bytes: a done pulse SHALL follow bytes 31 and 63, and RADD SHALL wrap 31 to 0 twice.
